// File: rtl/limb_normalizer.sv
// Serial carry propagation from redundant signed limbs to canonical
// two's-complement words, one word per accepted output beat.
module limb_normalizer #(
    parameter int NUM_LIMBS = 35,
    parameter int BIT_LEN   = 17,
    parameter int WORD_LEN  = 16,
    parameter int CARRY_LEN = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [BIT_LEN:0]      in_limb [NUM_LIMBS],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WORD_LEN-1:0]          out_word,
    output logic [$clog2(NUM_LIMBS)-1:0] out_idx,
    output logic                         out_last,
    output logic                         out_neg,
    output logic                         out_ovf
);

    localparam int IW = $clog2(NUM_LIMBS);
    localparam int SW = BIT_LEN + 2;
    localparam logic [IW-1:0] LAST = IW'(NUM_LIMBS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                  state;
    logic signed [BIT_LEN:0] limb_q [NUM_LIMBS];
    logic [IW-1:0]           idx;
    logic signed [CARRY_LEN-1:0] carry;

    logic signed [SW-1:0] s;
    logic signed [SW-1:0] ncarry;
    logic                 run;
    logic                 last;
    logic                 wide;

    assign run    = (state == RUN);
    assign s      = SW'(limb_q[idx]) + SW'(carry);
    assign ncarry = s >>> WORD_LEN;
    assign last   = run && (idx == LAST);
    // carry-out outside {0,-1} means the value needs more than the word span
    assign wide   = !((&ncarry) || (~|ncarry));

    assign in_ready  = !run;
    assign out_valid = run;
    assign out_word  = run ? s[WORD_LEN-1:0] : '0;
    assign out_idx   = run ? idx : '0;
    assign out_last  = last;
    assign out_neg   = last && ncarry[SW-1];
    assign out_ovf   = last && wide;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= '0;
            for (int i = 0; i < NUM_LIMBS; i++) begin
                limb_q[i] <= '0;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        limb_q <= in_limb;
                        carry  <= '0;
                        idx    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (out_ready) begin
                        carry <= CARRY_LEN'(ncarry);
                        if (idx == LAST) begin
                            idx   <= '0;
                            state <= IDLE;
                        end else begin
                            idx <= idx + IW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_limb_normalizer.sv
// Scoreboard bench for limb_normalizer: big-integer reference model,
// randomized vectors with backpressure, stall and mid-run reset cases.
module tb_limb_normalizer;

    localparam int NL = 35;
    localparam int BL = 17;
    localparam int WL = 16;
    localparam int CL = 4;
    localparam int IW = $clog2(NL);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 in_valid;
    logic                 in_ready;
    logic signed [BL:0]   in_limb [NL];
    logic                 out_valid;
    logic                 out_ready;
    logic [WL-1:0]        out_word;
    logic [IW-1:0]        out_idx;
    logic                 out_last;
    logic                 out_neg;
    logic                 out_ovf;

    logic                 n2_in_valid;
    logic                 n2_in_ready;
    logic signed [BL:0]   n2_limb [2];
    logic                 n2_out_valid;
    logic                 n2_out_ready;
    logic [WL-1:0]        n2_word;
    logic [0:0]           n2_idx;
    logic                 n2_last;
    logic                 n2_neg;
    logic                 n2_ovf;

    limb_normalizer #(
        .NUM_LIMBS(NL), .BIT_LEN(BL), .WORD_LEN(WL), .CARRY_LEN(CL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_limb(in_limb),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_idx(out_idx), .out_last(out_last),
        .out_neg(out_neg), .out_ovf(out_ovf)
    );

    limb_normalizer #(
        .NUM_LIMBS(2), .BIT_LEN(BL), .WORD_LEN(WL), .CARRY_LEN(CL)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(n2_in_valid), .in_ready(n2_in_ready), .in_limb(n2_limb),
        .out_valid(n2_out_valid), .out_ready(n2_out_ready),
        .out_word(n2_word), .out_idx(n2_idx), .out_last(n2_last),
        .out_neg(n2_neg), .out_ovf(n2_ovf)
    );

    typedef struct {
        logic [WL-1:0] w;
        int            idx;
        logic          last;
        logic          neg;
        logic          ovf;
    } exp_t;

    exp_t          sbq[$];
    exp_t          me;
    logic [WL-1:0] cur_w [NL];
    int            lv [NL];
    int            ntests = 0;
    int            nfail = 0;
    int            bp_mode = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    task automatic timeout_fail(input string nm);
        ntests++;
        nfail++;
        $display("FAIL %s: wait expired, required DUT event", nm);
    endtask

    // Reference: sum all limbs as one wide integer, then slice words
    task automatic push_vec();
        logic signed [639:0] tot;
        logic signed [639:0] t;
        logic signed [639:0] lim;
        logic                neg;
        logic                ovf;
        exp_t                e;
        tot = '0;
        for (int i = 0; i < NL; i++) begin
            t   = 640'(lv[i]);
            tot = tot + (t <<< (WL * i));
        end
        lim = 640'sd1 <<< (NL * WL);
        neg = (tot < 0);
        ovf = (tot >= lim) || (tot < -lim);
        for (int i = 0; i < NL; i++) begin
            e.w    = tot[WL*i +: WL];
            e.idx  = i;
            e.last = (i == NL - 1);
            e.neg  = e.last ? neg : 1'b0;
            e.ovf  = e.last ? ovf : 1'b0;
            cur_w[i] = e.w;
            sbq.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (bp_mode == 0) out_ready = 1'b1;
        else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sbq.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL extra_word: got idx %0d, required none",
                         out_idx);
            end else begin
                me = sbq.pop_front();
                chk("word", 64'(out_word), 64'(me.w));
                chk("idx", 64'(out_idx), 64'(me.idx));
                chk("last", 64'(out_last), 64'(me.last));
                chk("neg", 64'(out_neg), 64'(me.neg));
                chk("ovf", 64'(out_ovf), 64'(me.ovf));
            end
        end
    end

    task automatic send();
        int n;
        n = 0;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) timeout_fail("in_ready");
        push_vec();
        for (int i = 0; i < NL; i++) in_limb[i] = (BL+1)'(lv[i]);
        in_valid = 1'b1;
        @(posedge clk); #1;
        chk("first_valid", 64'(out_valid), 64'd1);
        chk("first_idx", 64'(out_idx), 64'd0);
        // garbage on the input side while running must be ignored
        in_valid = 1'b1;
        for (int i = 0; i < NL; i++) in_limb[i] = (BL+1)'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (!(out_valid && out_last) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!(out_valid && out_last)) timeout_fail("last_word");
        n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0 || !in_ready) timeout_fail("drain");
    endtask

    task automatic set_single(input int v);
        for (int i = 0; i < NL; i++) lv[i] = 0;
        lv[0] = v;
    endtask

    task automatic set_ctrl();
        lv[0] = 0;
        for (int i = 1; i < NL; i++) lv[i] = i - 1;
    endtask

    function automatic int rand_limb();
        int k;
        k = int'($urandom_range(0, 7));
        case (k)
            0: return -131072;
            1: return 131071;
            2: return -1;
            default: return int'($urandom_range(0, 262143)) - 131072;
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        in_valid = 1'b0;
        out_ready = 1'b1;
        n2_in_valid = 1'b0;
        n2_out_ready = 1'b1;
        n2_limb[0] = '0;
        n2_limb[1] = '0;
        for (int i = 0; i < NL; i++) in_limb[i] = '0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_word", 64'(out_word), 64'd0);
        chk("rst_idx", 64'(out_idx), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_neg", 64'(out_neg), 64'd0);
        chk("rst_ovf", 64'(out_ovf), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        n2_limb[0] = '0;
        n2_limb[1] = 18'sh1FFFF;
        n2_in_valid = 1'b1;
        @(posedge clk); #1;
        n2_in_valid = 1'b0;
        chk("n2_valid0", 64'(n2_out_valid), 64'd1);
        chk("n2_word0", 64'(n2_word), 64'h0000);
        chk("n2_last0", 64'(n2_last), 64'd0);
        chk("n2_ovf0", 64'(n2_ovf), 64'd0);
        @(posedge clk); #1;
        chk("n2_word1", 64'(n2_word), 64'hFFFF);
        chk("n2_idx1", 64'(n2_idx), 64'd1);
        chk("n2_last1", 64'(n2_last), 64'd1);
        chk("n2_ovf1", 64'(n2_ovf), 64'd1);
        chk("n2_neg1", 64'(n2_neg), 64'd0);
        @(posedge clk); #1;
        chk("n2_idle", 64'(n2_in_ready), 64'd1);

        set_single(1);       send(); drain();
        set_single(-1);      send(); drain();
        set_single(131071);  send(); drain();
        set_single(-131072); send(); drain();

        bp_mode = 1;
        for (int v = 0; v < 20; v++) begin
            for (int i = 0; i < NL; i++) lv[i] = rand_limb();
            send();
            drain();
        end

        bp_mode = 2;
        out_ready = 1'b1;
        set_ctrl();
        send();
        n = 0;
        while (out_idx != IW'(2) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_idx != IW'(2)) timeout_fail("stall_idx");
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("stall_valid", 64'(out_valid), 64'd1);
            chk("stall_idx", 64'(out_idx), 64'd2);
            chk("stall_word", 64'(out_word), 64'(cur_w[2]));
        end
        out_ready = 1'b1;
        bp_mode = 0;
        drain();

        send();
        n = 0;
        while (out_idx != IW'(10) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (out_idx != IW'(10)) timeout_fail("reset_idx");
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        sbq.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("midrst_ready", 64'(in_ready), 64'd1);
        chk("midrst_idx", 64'(out_idx), 64'd0);

        set_ctrl();
        send();
        drain();

        chk("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
